multi_edge_detect: RTL and testbench

//  Parametrised multi-channel synchroniser, glitch filter and edge detector; successor of the single-line SCL edge detector.

---
 rtl/edge_pkg.sv | 18 +
 rtl/edge_chan.sv | 105 ++++++++++
 rtl/multi_edge_detect.sv | 59 +++++
 tb/tb_multi_edge_detect.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// Shared defaults and types for the multi-channel synchroniser / glitch filter / edge detector.
package edge_pkg;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_FILT_LEN    = 3;

    typedef struct packed {
        logic rise;
        logic fall;
        logic level;
    } edge_evt_t;

    // Filter counter width: max(1, $clog2(filt_len)).
    function automatic int fc_width(input int filt_len);
        return ($clog2(filt_len) < 1) ? 1 : $clog2(filt_len);
    endfunction

endpackage

// File: rtl/edge_chan.sv
// One input channel: synchroniser chain, glitch filter, registered edge pulses and,
// with EDGE_CNT_EN defined, saturating rise/fall counters.
module edge_chan
    import edge_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILT_LEN    = DEF_FILT_LEN,
    parameter bit RST_LEVEL   = 1'b1
`ifdef EDGE_CNT_EN
    ,
    parameter int CNT_W       = 8
`endif
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             sig_i,
    input  logic             filt_en_i,
`ifdef EDGE_CNT_EN
    input  logic             cnt_clr_i,
    output logic [CNT_W-1:0] rise_cnt_o,
    output logic [CNT_W-1:0] fall_cnt_o,
`endif
    output edge_evt_t        evt_o
);

    localparam int FC_W = fc_width(FILT_LEN);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [FC_W-1:0]        fc_q, fc_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   ss;

    assign ss = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], sig_i};
        level_d = level_q;
        fc_d    = '0;
        if (ss != level_q) begin
            // Bypass, or the disagreement has now persisted for FILT_LEN samples.
            if (!filt_en_i || fc_q == FC_LAST) begin
                level_d = ss;
            end else begin
                fc_d = fc_q + 1'b1;
            end
        end
        rise_d = ~level_q &  level_d;
        fall_d =  level_q & ~level_d;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_q  <= {SYNC_STAGES{RST_LEVEL}};
            fc_q    <= '0;
            level_q <= RST_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            fc_q    <= fc_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign evt_o.rise  = rise_q;
    assign evt_o.fall  = fall_q;
    assign evt_o.level = level_q;

`ifdef EDGE_CNT_EN
    logic [CNT_W-1:0] rise_cnt_q, rise_cnt_d;
    logic [CNT_W-1:0] fall_cnt_q, fall_cnt_d;

    // Counts the visible pulse; a clear in the same cycle wins.
    always_comb begin
        rise_cnt_d = rise_cnt_q;
        fall_cnt_d = fall_cnt_q;
        if (cnt_clr_i) begin
            rise_cnt_d = '0;
            fall_cnt_d = '0;
        end else begin
            if (rise_q && rise_cnt_q != '1) rise_cnt_d = rise_cnt_q + 1'b1;
            if (fall_q && fall_cnt_q != '1) fall_cnt_d = fall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rise_cnt_q <= '0;
            fall_cnt_q <= '0;
        end else begin
            rise_cnt_q <= rise_cnt_d;
            fall_cnt_q <= fall_cnt_d;
        end
    end

    assign rise_cnt_o = rise_cnt_q;
    assign fall_cnt_o = fall_cnt_q;
`endif

endmodule

// File: rtl/multi_edge_detect.sv
// Multi-channel synchroniser, glitch filter and edge detector for the serial front-ends.
// Define EDGE_CNT_EN to add per-channel saturating edge counters and their ports.
module multi_edge_detect
    import edge_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILT_LEN    = DEF_FILT_LEN,
    parameter bit RST_LEVEL   = 1'b1,
    parameter int CNT_W       = 8
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic [NUM_CH-1:0]       sig_in,
    input  logic                    filt_en,
`ifdef EDGE_CNT_EN
    input  logic                    cnt_clr,
    output logic [NUM_CH*CNT_W-1:0] rise_cnt,
    output logic [NUM_CH*CNT_W-1:0] fall_cnt,
`endif
    output logic [NUM_CH-1:0]       level_out,
    output logic [NUM_CH-1:0]       rising_edge_found,
    output logic [NUM_CH-1:0]       falling_edge_found
);

    if (NUM_CH < 1 || SYNC_STAGES < 2 || FILT_LEN < 1 || CNT_W < 1) begin : g_param_check
        $error("multi_edge_detect: illegal parameter value");
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
        edge_evt_t evt;

        edge_chan #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILT_LEN   (FILT_LEN),
            .RST_LEVEL  (RST_LEVEL)
`ifdef EDGE_CNT_EN
            ,
            .CNT_W      (CNT_W)
`endif
        ) u_chan (
            .clk       (clk),
            .n_rst     (n_rst),
            .sig_i     (sig_in[ch]),
            .filt_en_i (filt_en),
`ifdef EDGE_CNT_EN
            .cnt_clr_i (cnt_clr),
            .rise_cnt_o(rise_cnt[ch*CNT_W +: CNT_W]),
            .fall_cnt_o(fall_cnt[ch*CNT_W +: CNT_W]),
`endif
            .evt_o     (evt)
        );

        assign level_out[ch]          = evt.level;
        assign rising_edge_found[ch]  = evt.rise;
        assign falling_edge_found[ch] = evt.fall;
    end

endmodule

// File: tb/tb_multi_edge_detect.sv
// Directed bench for multi_edge_detect at default parameters (4 channels, 2 sync stages, filter 3).
module tb_multi_edge_detect;

    logic        clk;
    logic        n_rst;
    logic [3:0]  sig_in;
    logic        filt_en;
    logic [3:0]  level_out;
    logic [3:0]  rising_edge_found;
    logic [3:0]  falling_edge_found;
`ifdef EDGE_CNT_EN
    logic        cnt_clr;
    logic [31:0] rise_cnt;
    logic [31:0] fall_cnt;
`endif

    multi_edge_detect dut (
        .clk               (clk),
        .n_rst             (n_rst),
        .sig_in            (sig_in),
        .filt_en           (filt_en),
`ifdef EDGE_CNT_EN
        .cnt_clr           (cnt_clr),
        .rise_cnt          (rise_cnt),
        .fall_cnt          (fall_cnt),
`endif
        .level_out         (level_out),
        .rising_edge_found (rising_edge_found),
        .falling_edge_found(falling_edge_found)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] sig;
        logic       filt;
        logic [3:0] lvl;
        logic [3:0] rise;
        logic [3:0] fall;
    } vec_t;

    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic void add(input logic [3:0] sig, input logic filt,
                                input logic [3:0] lvl, input logic [3:0] rise,
                                input logic [3:0] fall);
        vec_t v;
        v.sig = sig; v.filt = filt; v.lvl = lvl; v.rise = rise; v.fall = fall;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Called with n_rst low and sig_in = 0: release reset, expect falling pulse on the 5th clock.
    task automatic release_and_check(input string tag);
        chk({tag, " rst level"}, 32'(level_out), 32'hF);
        chk({tag, " rst rise"}, 32'(rising_edge_found), 32'h0);
        chk({tag, " rst fall"}, 32'(falling_edge_found), 32'h0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            chk($sformatf("%s clk%0d level", tag, k), 32'(level_out), (k < 5) ? 32'hF : 32'h0);
            chk($sformatf("%s clk%0d rise", tag, k), 32'(rising_edge_found), 32'h0);
            chk($sformatf("%s clk%0d fall", tag, k), 32'(falling_edge_found), (k == 5) ? 32'hF : 32'h0);
        end
    endtask

    initial begin
        n_rst   = 1'b0;
        sig_in  = 4'h0;
        filt_en = 1'b1;
`ifdef EDGE_CNT_EN
        cnt_clr = 1'b0;
`endif

        // Bypass mode: latency 3, simultaneous edges on all channels.
        add(4'hF, 0, 4'h0, 4'h0, 4'h0);
        add(4'hF, 0, 4'h0, 4'h0, 4'h0);
        add(4'hF, 0, 4'hF, 4'hF, 4'h0);
        add(4'hF, 0, 4'hF, 4'h0, 4'h0);
        add(4'h0, 0, 4'hF, 4'h0, 4'h0);
        add(4'h0, 0, 4'hF, 4'h0, 4'h0);
        add(4'h0, 0, 4'h0, 4'h0, 4'hF);
        add(4'h1, 0, 4'h0, 4'h0, 4'h0);
        add(4'h1, 0, 4'h0, 4'h0, 4'h0);
        add(4'h1, 0, 4'h1, 4'h1, 4'h0);
        add(4'h1, 0, 4'h1, 4'h0, 4'h0);
        add(4'hF, 0, 4'h1, 4'h0, 4'h0);
        add(4'hF, 0, 4'h1, 4'h0, 4'h0);
        add(4'hF, 0, 4'hF, 4'hE, 4'h0);
        add(4'hF, 0, 4'hF, 4'h0, 4'h0);
        // Filter on: ch1 falls with latency 5.
        add(4'hD, 1, 4'hF, 4'h0, 4'h0);
        add(4'hD, 1, 4'hF, 4'h0, 4'h0);
        add(4'hD, 1, 4'hF, 4'h0, 4'h0);
        add(4'hD, 1, 4'hF, 4'h0, 4'h0);
        add(4'hD, 1, 4'hD, 4'h0, 4'h2);
        add(4'hD, 1, 4'hD, 4'h0, 4'h0);
        // 2-cycle high glitch on ch1: suppressed.
        add(4'hF, 1, 4'hD, 4'h0, 4'h0);
        add(4'hF, 1, 4'hD, 4'h0, 4'h0);
        for (int i = 0; i < 6; i++) add(4'hD, 1, 4'hD, 4'h0, 4'h0);
        // 3-cycle high pulse on ch1: accepted as rise then fall.
        add(4'hF, 1, 4'hD, 4'h0, 4'h0);
        add(4'hF, 1, 4'hD, 4'h0, 4'h0);
        add(4'hF, 1, 4'hD, 4'h0, 4'h0);
        add(4'hD, 1, 4'hD, 4'h0, 4'h0);
        add(4'hD, 1, 4'hF, 4'h2, 4'h0);
        add(4'hD, 1, 4'hF, 4'h0, 4'h0);
        add(4'hD, 1, 4'hF, 4'h0, 4'h0);
        add(4'hD, 1, 4'hD, 4'h0, 4'h2);
        add(4'hD, 1, 4'hD, 4'h0, 4'h0);

        repeat (3) @(posedge clk);
        #1;
        release_and_check("init");

        foreach (vecs[i]) begin
            sig_in  = vecs[i].sig;
            filt_en = vecs[i].filt;
            @(posedge clk); #1;
            chk($sformatf("vec%0d level", i), 32'(level_out), 32'(vecs[i].lvl));
            chk($sformatf("vec%0d rise", i), 32'(rising_edge_found), 32'(vecs[i].rise));
            chk($sformatf("vec%0d fall", i), 32'(falling_edge_found), 32'(vecs[i].fall));
        end

        // Reset asserted mid-filter (fc=1 on every channel): level returns to 1 without a clock.
        filt_en = 1'b1;
        sig_in  = 4'h2;
        repeat (3) @(posedge clk);
        #3;
        n_rst = 1'b0;
        #1;
        chk("midrst async level", 32'(level_out), 32'hF);
        chk("midrst async rise", 32'(rising_edge_found), 32'h0);
        sig_in = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        release_and_check("midrst");

`ifdef EDGE_CNT_EN
        begin
            bit seen;
            filt_en = 1'b0;
            cnt_clr = 1'b1;
            @(posedge clk); #1;
            cnt_clr = 1'b0;
            chk("cnt clr rise", rise_cnt, 32'h0);
            chk("cnt clr fall", fall_cnt, 32'h0);
            for (int n = 0; n < 300; n++) begin
                sig_in[2] = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                sig_in[2] = 1'b0;
                repeat (3) @(posedge clk);
                #1;
            end
            repeat (2) @(posedge clk);
            #1;
            chk("cnt sat rise", rise_cnt, 32'h00FF_0000);
            chk("cnt sat fall", fall_cnt, 32'h00FF_0000);
            sig_in[2] = 1'b1;
            seen = 1'b0;
            for (int k = 0; k < 10 && !seen; k++) begin
                @(posedge clk); #1;
                seen = rising_edge_found[2];
            end
            chk("cnt rise pulse seen", 32'(seen), 32'h1);
            cnt_clr = 1'b1;
            @(posedge clk); #1;
            cnt_clr = 1'b0;
            chk("cnt clr with pulse rise", rise_cnt, 32'h0);
            sig_in[2] = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            chk("cnt after clr fall", fall_cnt, 32'h0001_0000);
            chk("cnt after clr rise", rise_cnt, 32'h0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
